// File: rtl/sal_tlp_tx_ctrl.sv
// SAL channel-0 TLP transmit sequencer: builds the 3DW/4DW header, passes the payload
// through with valid/ready, and owns the channel tag counter and busy/done status.
module sal_tlp_tx_ctrl #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       fmt_i,
  input  logic [4:0]       type_i,
  input  logic [2:0]       tc_i,
  input  logic [8:0]       length_i,
  input  logic [15:0]      requester_id_i,
  input  logic [15:0]      completer_id_i,
  input  logic [63:0]      addr_i,
  input  logic             pld_valid_i,
  input  logic [31:0]      pld_data_i,
  output logic             pld_ready_o,
  output logic             tlp_valid_o,
  output logic [31:0]      tlp_data_o,
  output logic             tlp_sop_o,
  output logic             tlp_eop_o,
  input  logic             tlp_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_drop_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned LEN_W  = 10;
  localparam int unsigned HCNT_W = 2;
  localparam int unsigned DW_W   = 32;
  localparam logic [4:0]  TYPE_CPL = 5'b01010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HCNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [TAG_W-1:0]    tag_q;

  logic [2:0]          fmt_q;
  logic [4:0]          type_q;
  logic [2:0]          tc_q;
  logic [LEN_W-1:0]    len10_q;
  logic [15:0]         req_id_q;
  logic [15:0]         cpl_id_q;
  logic [63:0]         addr_q;
  logic [TAG_W-1:0]    tag_lat_q;

  logic                start_acc;
  logic                tlp_done;
  logic                hdr_last;
  logic                pld_last;
  logic [LEN_W-1:0]    len10_in;
  logic [7:0]          tag8;
  logic [3:0]          last_be;
  logic [11:0]         byte_cnt;
  logic [DW_W-1:0]     hdr_dw;

  // A zero length field encodes the maximum 512-DW payload.
  assign len10_in = (length_i == 9'd0) ? LEN_W'(512) : LEN_W'(length_i);

  assign tag8     = 8'(tag_lat_q);
  assign last_be  = (len10_q > LEN_W'(1)) ? 4'hF : 4'h0;
  assign byte_cnt = {len10_q, 2'b00};
  assign hdr_last = (hdr_cnt_q == (fmt_q[0] ? HCNT_W'(3) : HCNT_W'(2)));
  assign pld_last = (beat_cnt_q == (len10_q - LEN_W'(1)));

  assign busy_o = (state_q != ST_IDLE);
  assign tag_o  = tag_q;

  // Header DW selected by the beat index from the latched configuration.
  always_comb begin
    hdr_dw = '0;
    if (hdr_cnt_q == HCNT_W'(0)) begin
      hdr_dw = {fmt_q, type_q, 1'b0, tc_q, 10'b0, len10_q};
    end else if (type_q == TYPE_CPL) begin
      case (hdr_cnt_q)
        HCNT_W'(1): hdr_dw = {cpl_id_q, 3'b000, 1'b0, byte_cnt};
        HCNT_W'(2): hdr_dw = {req_id_q, tag8, 1'b0, addr_q[6:0]};
        default:    hdr_dw = '0;
      endcase
    end else begin
      case (hdr_cnt_q)
        HCNT_W'(1): hdr_dw = {req_id_q, tag8, last_be, 4'hF};
        HCNT_W'(2): hdr_dw = fmt_q[0] ? addr_q[63:32] : {addr_q[31:2], 2'b00};
        default:    hdr_dw = {addr_q[31:2], 2'b00};
      endcase
    end
  end

  // Next-state and stream outputs.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    start_acc   = 1'b0;
    tlp_done    = 1'b0;
    tlp_valid_o = 1'b0;
    tlp_data_o  = '0;
    tlp_sop_o   = 1'b0;
    tlp_eop_o   = 1'b0;
    pld_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_HDR;
          hdr_cnt_d  = '0;
          beat_cnt_d = '0;
          start_acc  = 1'b1;
        end
      end

      ST_HDR: begin
        tlp_valid_o = 1'b1;
        tlp_data_o  = hdr_dw;
        tlp_sop_o   = (hdr_cnt_q == HCNT_W'(0));
        tlp_eop_o   = hdr_last & ~fmt_q[1];
        if (tlp_ready_i) begin
          if (!hdr_last) begin
            hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
          end else if (fmt_q[1]) begin
            state_d    = ST_PLD;
            beat_cnt_d = '0;
          end else begin
            state_d  = ST_IDLE;
            tlp_done = 1'b1;
          end
        end
      end

      ST_PLD: begin
        tlp_valid_o = pld_valid_i;
        tlp_data_o  = pld_data_i;
        pld_ready_o = tlp_ready_i;
        tlp_eop_o   = pld_valid_i & pld_last;
        if (pld_valid_i && tlp_ready_i) begin
          if (pld_last) begin
            state_d  = ST_IDLE;
            tlp_done = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, status pulses and latched configuration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hdr_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      tag_q        <= '0;
      done_o       <= 1'b0;
      start_drop_o <= 1'b0;
      fmt_q        <= '0;
      type_q       <= '0;
      tc_q         <= '0;
      len10_q      <= '0;
      req_id_q     <= '0;
      cpl_id_q     <= '0;
      addr_q       <= '0;
      tag_lat_q    <= '0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      done_o       <= tlp_done;
      start_drop_o <= start_i & (state_q != ST_IDLE);
      if (tlp_done) begin
        tag_q <= tag_q + TAG_W'(1);
      end
      if (start_acc) begin
        fmt_q     <= fmt_i;
        type_q    <= type_i;
        tc_q      <= tc_i;
        len10_q   <= len10_in;
        req_id_q  <= requester_id_i;
        cpl_id_q  <= completer_id_i;
        addr_q    <= addr_i;
        tag_lat_q <= tag_q;
      end
    end
  end

endmodule

// File: doc/sal_tlp_tx_ctrl.md
Name: sal_tlp_tx_ctrl

Overview:
- Transmit sequencer for the SAL channel-0 TLP path.
- On the one-cycle start pulse from the APB configuration block, it latches the header configuration and emits the TLP as a 32-bit DW stream with valid/ready handshake.
- Stream order: a 3DW or 4DW header, then the payload DWs pulled from a payload source.
- It also owns the channel's tag counter and reports busy/done status back toward the configuration space.

Parameters:
TAG_W, 8, width of the tag counter (1..8); the tag is zero-extended into the 8-bit header field.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start_i  input  1  single-cycle start pulse (ch0 start)
fmt_i  input  3  header fmt; bit0=4DW header, bit1=with data
type_i  input  5  header type; 5'b01010 = completion
tc_i  input  3  traffic class
length_i  input  9  payload length in DW; 0 encodes 512
requester_id_i  input  16  requester ID
completer_id_i  input  16  completer ID
addr_i  input  64  byte address
pld_valid_i  input  1  payload DW valid
pld_data_i  input  32  payload DW
pld_ready_o  output  1  payload DW accepted
tlp_valid_o  output  1  output DW valid
tlp_data_o  output  32  output DW
tlp_sop_o  output  1  first DW of TLP
tlp_eop_o  output  1  last DW of TLP
tlp_ready_i  input  1  downstream ready
busy_o  output  1  TLP in progress
done_o  output  1  one-cycle pulse, TLP complete
start_drop_o  output  1  one-cycle pulse, start ignored while busy
tag_o  output  TAG_W  tag to be used by the next TLP

Behaviour:
- Reset: synchronous, active-low.
  - FSM to IDLE; all outputs 0; tag 0.
  - Reset asserted mid-TLP aborts it immediately: no eop, no done.
- FSM states: IDLE, HDR, PLD.
- IDLE:
  - start_i latches all config inputs plus the current tag; FSM -> HDR.
  - busy_o=1 from the next cycle.
  - tlp_valid_o=1 on the cycle after start (latency 1).
- HDR:
  - Emits hdr_cnt 0..N-1, where N=4 if fmt[0] else 3.
  - A beat advances only when tlp_valid_o & tlp_ready_i; tlp_data_o must hold stable while stalled.
  - sop=1 on DW0.
  - On the last header beat:
    - if fmt[1]=0: eop=1, then -> IDLE.
    - else -> PLD.
- DW0: {fmt, type, 1'b0, tc, 10'b0, len10}. len10 = 10'd512 if length_i==0, else zero-extended length_i.
- Non-completion headers:
  - DW1: {requester_id, tag8, lastBE, 4'hF}; lastBE = 4'hF if len10>1, else 4'h0.
  - 3DW: DW2 = {addr[31:2], 2'b00}.
  - 4DW: DW2 = addr[63:32]; DW3 = {addr[31:2], 2'b00}.
- Completion headers (type==5'b01010):
  - DW1: {completer_id, 3'b000, 1'b0, bytecount12}; bytecount12 = len10*4, truncated to 12 bits (512 -> 12'h800).
  - DW2: {requester_id, tag8, 1'b0, addr[6:0]}.
  - Header length still follows fmt[0].
- PLD:
  - Pass-through: tlp_valid_o=pld_valid_i, tlp_data_o=pld_data_i, pld_ready_o=tlp_ready_i. pld_ready_o=0 in all other states.
  - Beat counter counts accepted DWs; eop=1 on beat len10; then -> IDLE.
- Completion of a TLP:
  - On acceptance of the eop beat: done_o pulses on the next cycle; busy_o drops on that same cycle.
  - tag increments by 1 at that point, wrapping modulo 2^TAG_W.
- start_i while busy: ignored; start_drop_o pulses the next cycle; latched config unchanged.
- start_i in the cycle busy_o falls is accepted normally.

Test Plan:
- MRd 3DW: fmt=000, type=0, tc=0, len=1, req=0x1234, addr=0x10000040, ready=1 -> DW0=0x00000001 (sop), DW1=0x1234000F, DW2=0x10000040 (eop). Then done pulse; tag_o=1.
- MWr 4DW, len=2, addr=0x1_23456780, tag=1, tlp_ready toggling every cycle -> DW0=0x60000002, DW1=0x123401FF, DW2=0x00000001, DW3=0x23456780, then 2 payload DWs with eop on the 2nd. Data stable across every stall.
- CplD: fmt=010, type=01010, len=4, cpl=0xABCD, req=0x0100, addr[6:0]=0x44, tag=2 -> DW0=0x4A000004, DW1=0xABCD0010, DW2=0x01000244, then 4 payload DWs.
- length_i=0 with data -> DW0[9:0]=0x200; exactly 512 payload beats; eop on the 512th; pld_valid gaps stall the output without dropping beats.
- start_i pulsed during HDR -> start_drop_o pulse; the in-flight TLP is unchanged; no second TLP.
- rst_n low during PLD beat 3 -> next cycle all outputs 0, tag 0, no done. A fresh start then produces a correct TLP.
